// File: rtl/csi_pkt_pkg.sv
// csi_pkt_pkg
// Shared types and helpers for the CSI-2 packet builder.
//   hdr_t      : packed header fields, laid out exactly as header bits 23:0
//   state_e    : packet builder FSM states
//   CRC_POLY   : reflected CRC-16 polynomial
//   CRC_INIT   : CRC-16 seed value
//   csi_ecc6() : CSI-2 6-bit Hamming code over the 24 header bits
package csi_pkt_pkg;

   localparam logic [15:0] CRC_POLY = 16'h8408;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   // Field order matches the wire: WC in bits 23:8, VC in 7:6, DT in 5:0
   typedef struct packed {
      logic [15:0] wc;
      logic [1:0]  vc;
      logic [5:0]  dt;
   } hdr_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLD  = 2'd1,
      ST_CRC  = 2'd2
   } state_e;

   // Each parity bit covers a fixed subset of the 24 header bits
   function automatic logic [5:0] csi_ecc6(input logic [23:0] d);
      logic [5:0] p;
      p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^
             d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
      p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^
             d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
      p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^
             d[18] ^ d[20] ^ d[21] ^ d[22];
      p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^
             d[19] ^ d[20] ^ d[21] ^ d[23];
      p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^
             d[19] ^ d[20] ^ d[22] ^ d[23];
      p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^
             d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
      return p;
   endfunction

endpackage

// File: rtl/csi_crc16_x4.sv
// csi_crc16_x4
// Running CRC-16 (reflected 0x8408) folding one 32-bit word per enabled cycle,
// byte0 (bits 7:0) first, each byte LSB first.
//   clk_i, rst_i : clock, asynchronous active-high reset (CRC -> 16'hFFFF)
//   clear_i      : reseed CRC to 16'hFFFF (wins over en_i)
//   en_i         : fold data_i into the CRC
//   data_i       : 32-bit payload word
//   crc_q_o      : current CRC register
//   crc_next_o   : CRC after folding data_i into crc_q_o
import csi_pkt_pkg::*;

module csi_crc16_x4 (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   input  logic        en_i,
   input  logic [31:0] data_i,
   output logic [15:0] crc_q_o,
   output logic [15:0] crc_next_o
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;
   logic        fb;

   // Bit-serial LFSR unrolled over all 32 data bits; bit 0 of the word is
   // the first bit on the wire, so walking i upward gives wire order.
   always_comb begin
      crc_d = crc_q;
      fb    = 1'b0;
      for (int i = 0; i < 32; i++) begin
         fb    = crc_d[0] ^ data_i[i];
         crc_d = {1'b0, crc_d[15:1]} ^ (fb ? CRC_POLY : 16'h0000);
      end
   end

   // CRC register: reseed on clear, otherwise advance when enabled
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         crc_q <= CRC_INIT;
      end else if (clear_i) begin
         crc_q <= CRC_INIT;
      end else if (en_i) begin
         crc_q <= crc_d;
      end
   end

   assign crc_q_o    = crc_q;
   assign crc_next_o = crc_d;

endmodule

// File: rtl/csi_pkt_builder.sv
// csi_pkt_builder
// Frames CSI-2 short/long packets as 32-bit words for the CSI transmit core.
//   csi_clk_i, rst_i        : clock, asynchronous active-high reset
//   cmd_*_i / cmd_ready_o   : packet command (long flag, VC, DT, WC)
//   in_data_i/in_valid_i/in_ready_o : payload word stream, byte0 in bits 7:0
//   out_data_o/out_be_o/out_sop_o/out_eop_o/out_valid_o/out_ready_i :
//                             registered packet word stream
//   err_wc_o                : one-cycle pulse on a long WC not multiple of 4
import csi_pkt_pkg::*;

module csi_pkt_builder #(
   parameter int P_CIN_DATA_WIDTH = 32,
   parameter int P_WC_WIDTH       = 16
) (
   input  logic                        csi_clk_i,
   input  logic                        rst_i,
   input  logic                        cmd_valid_i,
   output logic                        cmd_ready_o,
   input  logic                        cmd_long_i,
   input  logic [1:0]                  cmd_vc_i,
   input  logic [5:0]                  cmd_dt_i,
   input  logic [P_WC_WIDTH-1:0]       cmd_wc_i,
   input  logic [P_CIN_DATA_WIDTH-1:0] in_data_i,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   output logic [P_CIN_DATA_WIDTH-1:0] out_data_o,
   output logic [3:0]                  out_be_o,
   output logic                        out_sop_o,
   output logic                        out_eop_o,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic                        err_wc_o
);

   state_e      state_q, state_d;
   logic [15:0] rem_q, rem_d;
   logic [31:0] out_data_q, out_data_d;
   logic [3:0]  out_be_q, out_be_d;
   logic        out_sop_q, out_sop_d;
   logic        out_eop_q, out_eop_d;
   logic        out_valid_q, out_valid_d;
   logic        err_wc_q, err_wc_d;

   logic        free;
   logic        cmd_rdy, in_rdy;
   logic        crc_clr, crc_en;
   logic [15:0] crc_q, crc_next, footer_crc;
   hdr_t        hdr;

   csi_crc16_x4 u_crc (
      .clk_i      (csi_clk_i),
      .rst_i      (rst_i),
      .clear_i    (crc_clr),
      .en_i       (crc_en),
      .data_i     (in_data_i),
      .crc_q_o    (crc_q),
      .crc_next_o (crc_next)
   );

   // The output register can take a new word when empty or being drained
   assign free = ~out_valid_q | out_ready_i;

   // Footer value is the running CRC including any word folded this cycle
   assign footer_crc = crc_en ? crc_next : crc_q;

   // Next-state and output-register load logic. Long packets carry WC
   // rounded down to a word multiple, and exactly that many bytes are used.
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      out_data_d  = out_data_q;
      out_be_d    = out_be_q;
      out_sop_d   = out_sop_q;
      out_eop_d   = out_eop_q;
      out_valid_d = out_valid_q & ~out_ready_i;
      err_wc_d    = 1'b0;
      crc_clr     = 1'b0;
      crc_en      = 1'b0;
      cmd_rdy     = 1'b0;
      in_rdy      = 1'b0;
      hdr.vc      = cmd_vc_i;
      hdr.dt      = cmd_dt_i;
      hdr.wc      = cmd_long_i ? {cmd_wc_i[15:2], 2'b00} : cmd_wc_i;

      unique case (state_q)
         ST_IDLE: begin
            cmd_rdy = free;
            if (cmd_valid_i && free) begin
               out_data_d  = {2'b00, csi_ecc6(hdr), hdr};
               out_be_d    = 4'hF;
               out_sop_d   = 1'b1;
               out_eop_d   = ~cmd_long_i;
               out_valid_d = 1'b1;
               if (cmd_long_i) begin
                  rem_d    = hdr.wc;
                  crc_clr  = 1'b1;
                  err_wc_d = |cmd_wc_i[1:0];
                  state_d  = (hdr.wc == 16'd0) ? ST_CRC : ST_PLD;
               end
            end
         end
         ST_PLD: begin
            in_rdy = free;
            if (in_valid_i && free) begin
               out_data_d  = in_data_i;
               out_be_d    = 4'hF;
               out_sop_d   = 1'b0;
               out_eop_d   = 1'b0;
               out_valid_d = 1'b1;
               crc_en      = 1'b1;
               rem_d       = rem_q - 16'd4;
               if (rem_q == 16'd4) begin
                  state_d = ST_CRC;
               end
            end
         end
         ST_CRC: begin
            if (free) begin
               out_data_d  = {16'h0000, footer_crc};
               out_be_d    = 4'b0011;
               out_sop_d   = 1'b0;
               out_eop_d   = 1'b1;
               out_valid_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, remaining-byte counter and output register
   always_ff @(posedge csi_clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         rem_q       <= 16'd0;
         out_data_q  <= 32'd0;
         out_be_q    <= 4'd0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         out_valid_q <= 1'b0;
         err_wc_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         out_data_q  <= out_data_d;
         out_be_q    <= out_be_d;
         out_sop_q   <= out_sop_d;
         out_eop_q   <= out_eop_d;
         out_valid_q <= out_valid_d;
         err_wc_q    <= err_wc_d;
      end
   end

   // Commands are refused while reset is held so nothing is taken mid-reset
   assign cmd_ready_o = cmd_rdy & ~rst_i;
   assign in_ready_o  = in_rdy;
   assign out_data_o  = out_data_q;
   assign out_be_o    = out_be_q;
   assign out_sop_o   = out_sop_q;
   assign out_eop_o   = out_eop_q;
   assign out_valid_o = out_valid_q;
   assign err_wc_o    = err_wc_q;

endmodule
